// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - RV32I issue stage: decodes into an external ALU, registers result and redirect.
module alu_issue_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk_w_i,
  input  logic            rst_w_i_h,
  input  logic            in_valid_w_i_h,
  output logic            in_ready_w_o_h,
  input  logic [31:0]     instr_w_i,
  input  logic [XLEN-1:0] pc_w_i,
  input  logic [XLEN-1:0] rs1_data_w_i,
  input  logic [XLEN-1:0] rs2_data_w_i,
  input  logic            flush_w_i_h,
  output logic [XLEN-1:0] a_data_w_o,
  output logic [XLEN-1:0] b_data_w_o,
  output logic [3:0]      alu_control_w_o,
  input  logic [XLEN-1:0] alu_res_w_i,
  input  logic            eq_w_i_h,
  input  logic            ltu_w_i_h,
  input  logic            lts_w_i_h,
  output logic            out_valid_w_o_h,
  input  logic            out_ready_w_i_h,
  output logic [4:0]      rd_addr_w_o,
  output logic [XLEN-1:0] rd_data_w_o,
  output logic            rd_we_w_o_h,
  output logic            br_taken_w_o_h,
  output logic [XLEN-1:0] br_target_w_o,
  output logic            illegal_w_o_h
);
  typedef enum logic [2:0] {K_ALU, K_BR, K_JAL, K_JALR, K_ILL} kind_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  logic            e_valid, w_valid, w_adv, e_load;
  kind_t           d_kind, e_kind;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3, e_f3;
  logic [4:0]      e_rd;
  logic [3:0]      d_ctrl;
  logic [XLEN-1:0] imm_i, imm_u, imm_b, imm_j;
  logic [XLEN-1:0] d_a, d_b, d_off, e_pc, e_off;
  logic [XLEN-1:0] pc_plus_off, pc_plus_4;
  logic [XLEN-1:0] n_data, n_target;
  logic            n_we, n_taken, n_ill, br_cond;

  assign w_adv          = !w_valid || out_ready_w_i_h;
  assign in_ready_w_o_h = !e_valid || w_adv;
  assign e_load         = in_valid_w_i_h && in_ready_w_o_h && !flush_w_i_h;

  assign opcode = instr_w_i[6:0];
  assign funct3 = instr_w_i[14:12];
  assign funct7 = instr_w_i[31:25];
  assign imm_i  = {{20{instr_w_i[31]}}, instr_w_i[31:20]};
  assign imm_u  = {instr_w_i[31:12], 12'b0};
  assign imm_b  = {{19{instr_w_i[31]}}, instr_w_i[31], instr_w_i[7], instr_w_i[30:25], instr_w_i[11:8], 1'b0};
  assign imm_j  = {{11{instr_w_i[31]}}, instr_w_i[31], instr_w_i[19:12], instr_w_i[20], instr_w_i[30:21], 1'b0};

  always_comb begin
    d_kind = K_ILL;
    d_a    = '0;
    d_b    = '0;
    d_ctrl = 4'b0000;
    d_off  = '0;
    case (opcode)
      OPC_OP: begin
        if (funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))) begin
          d_kind = K_ALU;
          d_a    = rs1_data_w_i;
          d_b    = rs2_data_w_i;
          d_ctrl = {funct7[5], funct3};
        end
      end
      OPC_OPIMM: begin
        // Shift-immediates carry funct7 in imm[11:5]; only SRAI may set bit 30.
        if (!((funct3 == 3'b001 && funct7 != 7'h00) ||
              (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20))) begin
          d_kind = K_ALU;
          d_a    = rs1_data_w_i;
          d_b    = imm_i;
          d_ctrl = {funct3 == 3'b101 && funct7[5], funct3};
        end
      end
      OPC_LUI: begin
        d_kind = K_ALU;
        d_b    = imm_u;
      end
      OPC_AUIPC: begin
        d_kind = K_ALU;
        d_a    = pc_w_i;
        d_b    = imm_u;
      end
      OPC_BRANCH: begin
        if (funct3 != 3'b010 && funct3 != 3'b011) begin
          d_kind = K_BR;
          d_a    = rs1_data_w_i;
          d_b    = rs2_data_w_i;
          d_ctrl = 4'b1000;
          d_off  = imm_b;
        end
      end
      OPC_JAL: begin
        d_kind = K_JAL;
        d_a    = pc_w_i;
        d_b    = XLEN'(4);
        d_off  = imm_j;
      end
      OPC_JALR: begin
        if (funct3 == 3'b000) begin
          d_kind = K_JALR;
          d_a    = rs1_data_w_i;
          d_b    = imm_i;
        end
      end
      default: d_kind = K_ILL;
    endcase
  end

  // ALU drive registers only load on accept, so they hold while E is empty.
  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h) begin
      e_valid         <= 1'b0;
      e_kind          <= K_ALU;
      e_f3            <= '0;
      e_rd            <= '0;
      e_pc            <= '0;
      e_off           <= '0;
      a_data_w_o      <= '0;
      b_data_w_o      <= '0;
      alu_control_w_o <= '0;
    end else begin
      if (flush_w_i_h)         e_valid <= 1'b0;
      else if (in_ready_w_o_h) e_valid <= in_valid_w_i_h;
      if (e_load) begin
        e_kind          <= d_kind;
        e_f3            <= funct3;
        e_rd            <= instr_w_i[11:7];
        e_pc            <= pc_w_i;
        e_off           <= d_off;
        a_data_w_o      <= d_a;
        b_data_w_o      <= d_b;
        alu_control_w_o <= d_ctrl;
      end
    end
  end

  assign pc_plus_off = e_pc + e_off;
  assign pc_plus_4   = e_pc + XLEN'(4);

  always_comb begin
    case (e_f3)
      3'b000:  br_cond = eq_w_i_h;
      3'b001:  br_cond = !eq_w_i_h;
      3'b100:  br_cond = lts_w_i_h;
      3'b101:  br_cond = !lts_w_i_h;
      3'b110:  br_cond = ltu_w_i_h;
      3'b111:  br_cond = !ltu_w_i_h;
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    n_data   = alu_res_w_i;
    n_we     = e_rd != 5'd0;
    n_taken  = 1'b0;
    n_target = '0;
    n_ill    = 1'b0;
    case (e_kind)
      K_ALU: ;
      K_BR: begin
        n_we     = 1'b0;
        n_taken  = br_cond;
        n_target = pc_plus_off;
      end
      K_JAL: begin
        n_taken  = 1'b1;
        n_target = pc_plus_off;
      end
      K_JALR: begin
        n_data   = pc_plus_4;
        n_taken  = 1'b1;
        n_target = {alu_res_w_i[XLEN-1:1], 1'b0};
      end
      default: begin
        n_we  = 1'b0;
        n_ill = 1'b1;
      end
    endcase
    if (!n_we) n_data = '0;
  end

  always_ff @(posedge clk_w_i or posedge rst_w_i_h) begin
    if (rst_w_i_h) begin
      w_valid        <= 1'b0;
      rd_addr_w_o    <= '0;
      rd_data_w_o    <= '0;
      rd_we_w_o_h    <= 1'b0;
      br_taken_w_o_h <= 1'b0;
      br_target_w_o  <= '0;
      illegal_w_o_h  <= 1'b0;
    end else begin
      if (flush_w_i_h) w_valid <= 1'b0;
      else if (w_adv)  w_valid <= e_valid;
      if (w_adv && e_valid && !flush_w_i_h) begin
        rd_addr_w_o    <= e_rd;
        rd_data_w_o    <= n_data;
        rd_we_w_o_h    <= n_we;
        br_taken_w_o_h <= n_taken;
        br_target_w_o  <= n_target;
        illegal_w_o_h  <= n_ill;
      end
    end
  end

  assign out_valid_w_o_h = w_valid;
endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - directed vectors, stall/flush/reset sequences and randomized scoreboard for alu_issue_stage.
module tb_alu_issue_stage;
  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b1;
  logic [31:0] instr = '0, pc = '0, rs1 = '0, rs2 = '0;
  logic [31:0] a_data, b_data, alu_res, rd_data, br_target;
  logic [3:0]  alu_control;
  logic        eq, ltu, lts, rd_we, br_taken, illegal;
  logic [4:0]  rd_addr;

  int checks = 0, failures = 0;
  bit sb_on = 1'b0;

  typedef struct {
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic        rd_we, br_taken, illegal;
    logic [31:0] br_target;
  } res_t;

  typedef struct {
    logic [31:0] instr, pc, rs1, rs2;
    logic        chk_ctrl;
    logic [3:0]  ctrl;
    res_t        exp;
  } vec_t;

  res_t q[$];

  alu_issue_stage #(.XLEN(32)) dut (
    .clk_w_i(clk), .rst_w_i_h(rst), .in_valid_w_i_h(in_valid), .in_ready_w_o_h(in_ready),
    .instr_w_i(instr), .pc_w_i(pc), .rs1_data_w_i(rs1), .rs2_data_w_i(rs2),
    .flush_w_i_h(flush), .a_data_w_o(a_data), .b_data_w_o(b_data),
    .alu_control_w_o(alu_control), .alu_res_w_i(alu_res), .eq_w_i_h(eq),
    .ltu_w_i_h(ltu), .lts_w_i_h(lts), .out_valid_w_o_h(out_valid),
    .out_ready_w_i_h(out_ready), .rd_addr_w_o(rd_addr), .rd_data_w_o(rd_data),
    .rd_we_w_o_h(rd_we), .br_taken_w_o_h(br_taken), .br_target_w_o(br_target),
    .illegal_w_o_h(illegal)
  );

  always #5 clk = ~clk;

  // External ALU
  always_comb begin
    case (alu_control)
      4'b0000: alu_res = a_data + b_data;
      4'b0001: alu_res = a_data << b_data[4:0];
      4'b0010: alu_res = {31'b0, $signed(a_data) < $signed(b_data)};
      4'b0011: alu_res = {31'b0, a_data < b_data};
      4'b0100: alu_res = a_data ^ b_data;
      4'b0101: alu_res = a_data >> b_data[4:0];
      4'b0110: alu_res = a_data | b_data;
      4'b0111: alu_res = a_data & b_data;
      4'b1000: alu_res = a_data - b_data;
      4'b1101: alu_res = $unsigned($signed(a_data) >>> b_data[4:0]);
      default: alu_res = '0;
    endcase
    eq  = alu_res == 32'd0;
    ltu = a_data < b_data;
    lts = $signed(a_data) < $signed(b_data);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] sem(input logic [2:0] f3, input logic alt, input logic [31:0] x, input logic [31:0] y);
    case (f3)
      3'd0: return alt ? x - y : x + y;
      3'd1: return x << y[4:0];
      3'd2: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd3: return (x < y) ? 32'd1 : 32'd0;
      3'd4: return x ^ y;
      3'd5: return alt ? $unsigned($signed(x) >>> y[4:0]) : x >> y[4:0];
      3'd6: return x | y;
      default: return x & y;
    endcase
  endfunction

  // Architectural reference: RV32I semantics computed directly from the instruction.
  function automatic res_t ref_exec(input logic [31:0] ins, input logic [31:0] p, input logic [31:0] x, input logic [31:0] y);
    res_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [31:0] ii, iu, ib, ij, val;
    logic legal, br, tk;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25];
    ii = {{20{ins[31]}}, ins[31:20]};
    iu = {ins[31:12], 12'b0};
    ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    legal = 1'b1; br = 1'b0; tk = 1'b0; val = '0;
    r.br_target = '0;
    case (op)
      7'h33: begin
        legal = f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
        val = sem(f3, f7[5], x, y);
      end
      7'h13: begin
        if (f3 == 3'd1) legal = f7 == 7'h00;
        if (f3 == 3'd5) legal = f7 == 7'h00 || f7 == 7'h20;
        val = sem(f3, f3 == 3'd5 && f7[5], x, ii);
      end
      7'h37: val = iu;
      7'h17: val = p + iu;
      7'h63: begin
        br = 1'b1;
        legal = f3 != 3'd2 && f3 != 3'd3;
        case (f3)
          3'd0: tk = x == y;
          3'd1: tk = x != y;
          3'd4: tk = $signed(x) < $signed(y);
          3'd5: tk = $signed(x) >= $signed(y);
          3'd6: tk = x < y;
          default: tk = x >= y;
        endcase
        r.br_target = p + ib;
      end
      7'h6F: begin val = p + 4; tk = 1'b1; r.br_target = p + ij; end
      7'h67: begin legal = f3 == 3'd0; val = p + 4; tk = 1'b1; r.br_target = (x + ii) & 32'hFFFF_FFFE; end
      default: legal = 1'b0;
    endcase
    r.rd_addr  = ins[11:7];
    r.illegal  = !legal;
    r.br_taken = legal && tk;
    if (!legal) r.br_target = '0;
    r.rd_we    = legal && !br && ins[11:7] != 5'd0;
    r.rd_data  = r.rd_we ? val : 32'd0;
    return r;
  endfunction

  task automatic chk_out(input string tag, input res_t e);
    chk({tag, "_illegal"}, 32'(illegal), 32'(e.illegal));
    chk({tag, "_rd_we"}, 32'(rd_we), 32'(e.rd_we));
    chk({tag, "_rd_data"}, rd_data, e.rd_data);
    chk({tag, "_br_taken"}, 32'(br_taken), 32'(e.br_taken));
    chk({tag, "_br_target"}, br_target, e.br_target);
    if (e.rd_we) chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(e.rd_addr));
  endtask

  // Scoreboard monitor for the randomized phase
  always @(negedge clk) begin
    if (sb_on) begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("sb_unexpected_output", 32'd1, 32'd0);
        else chk_out("sb", q.pop_front());
      end
      if (flush) q.delete();
      else if (in_valid && in_ready) q.push_back(ref_exec(instr, pc, rs1, rs2));
    end
  end

  function automatic logic [31:0] addi(input int rd, input int imm);
    return (32'(imm) << 20) | (32'(rd) << 7) | 32'h13;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [6:0] f7;
    int k;
    w = $urandom();
    k = $urandom_range(0, 3);
    f7 = (k == 0) ? 7'h00 : (k == 1) ? 7'h20 : (k == 2) ? 7'h01 : w[31:25];
    case ($urandom_range(0, 8))
      0: begin w[6:0] = 7'h33; w[31:25] = f7; end
      1: begin w[6:0] = 7'h13; if (w[13:12] == 2'b01) w[31:25] = f7; end
      2: w[6:0] = 7'h37;
      3: w[6:0] = 7'h17;
      4, 5: w[6:0] = 7'h63;
      6: w[6:0] = 7'h6F;
      7: begin w[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
      default: ;
    endcase
    return w;
  endfunction

  vec_t vecs[14];

  initial begin
    vec_t v;
    int got, sent;
    bit acc;
    logic [31:0] x;

    vecs[0]  = '{32'h00500093, 32'h0,   32'h0,        32'h0,        1, 4'b0000, '{5'd1, 32'd5,        1, 0, 0, 32'h0}};
    vecs[1]  = '{32'h402081B3, 32'h0,   32'd7,        32'd9,        1, 4'b1000, '{5'd3, 32'hFFFFFFFE, 1, 0, 0, 32'h0}};
    vecs[2]  = '{32'h0020C463, 32'h100, 32'hFFFFFFFF, 32'd1,        1, 4'b1000, '{5'd8, 32'h0,        0, 1, 0, 32'h108}};
    vecs[3]  = '{32'h0020E463, 32'h100, 32'hFFFFFFFF, 32'd1,        1, 4'b1000, '{5'd8, 32'h0,        0, 0, 0, 32'h108}};
    vecs[4]  = '{32'hFFFFFFFF, 32'h0,   32'h0,        32'h0,        0, 4'b0000, '{5'd0, 32'h0,        0, 0, 1, 32'h0}};
    vecs[5]  = '{32'h008100E7, 32'h40,  32'h1001,     32'h0,        1, 4'b0000, '{5'd1, 32'h44,       1, 1, 0, 32'h1008}};
    vecs[6]  = '{32'h123452B7, 32'h0,   32'h0,        32'h0,        1, 4'b0000, '{5'd5, 32'h12345000, 1, 0, 0, 32'h0}};
    vecs[7]  = '{32'h00001317, 32'h200, 32'h0,        32'h0,        1, 4'b0000, '{5'd6, 32'h1200,     1, 0, 0, 32'h0}};
    vecs[8]  = '{32'h010000EF, 32'h300, 32'h0,        32'h0,        1, 4'b0000, '{5'd1, 32'h304,      1, 1, 0, 32'h310}};
    vecs[9]  = '{32'h4040D213, 32'h0,   32'h80000000, 32'h0,        1, 4'b1101, '{5'd4, 32'hF8000000, 1, 0, 0, 32'h0}};
    vecs[10] = '{32'h40409213, 32'h0,   32'h1,        32'h0,        0, 4'b0000, '{5'd0, 32'h0,        0, 0, 1, 32'h0}};
    vecs[11] = '{32'h00208033, 32'h0,   32'd3,        32'd4,        1, 4'b0000, '{5'd0, 32'h0,        0, 0, 0, 32'h0}};
    vecs[12] = '{32'h00208463, 32'h100, 32'd5,        32'd5,        1, 4'b1000, '{5'd8, 32'h0,        0, 1, 0, 32'h108}};
    vecs[13] = '{32'h022081B3, 32'h0,   32'd2,        32'd3,        0, 4'b0000, '{5'd0, 32'h0,        0, 0, 1, 32'h0}};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_a_data", a_data, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    rst = 1'b0;

    // Directed vectors, one at a time with out_ready held high
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      @(posedge clk); #1;
      instr = v.instr; pc = v.pc; rs1 = v.rs1; rs2 = v.rs2; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      if (v.chk_ctrl) chk($sformatf("vec%0d_ctrl", i), 32'(alu_control), 32'(v.ctrl));
      @(negedge clk);
      chk($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk_out($sformatf("vec%0d", i), v.exp);
    end

    // Four ADDIs against a stalled consumer
    @(posedge clk); #1;
    rs1 = 0; out_ready = 1'b0; instr = addi(1, 10); in_valid = 1'b1;
    @(posedge clk); #1;
    instr = addi(2, 11);
    @(posedge clk); #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    instr = addi(3, 12);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_data", rd_data, 32'd10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    sent = 2; got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("stream_rd_data", rd_data, 32'(10 + got));
        chk("stream_rd_addr", 32'(rd_addr), 32'(1 + got));
        got++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent < 4) instr = addi(sent + 1, 10 + sent);
        else in_valid = 1'b0;
      end
    end
    chk("stream_count", 32'(got), 32'd4);
    @(negedge clk);
    chk("stream_no_dup", 32'(out_valid), 32'd0);

    // Flush with a full pipeline and a simultaneous offer
    @(posedge clk); #1;
    out_ready = 1'b0; instr = addi(5, 1); in_valid = 1'b1;
    @(posedge clk); #1;
    instr = addi(6, 2);
    @(posedge clk); #1;
    instr = addi(7, 3); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    got = 0;
    repeat (3) begin
      @(negedge clk);
      if (out_valid) got++;
    end
    chk("flush_nothing_retained", 32'(got), 32'd0);

    // Asynchronous reset pulse mid-stream
    @(posedge clk); #1;
    out_ready = 1'b0; rs1 = 32'd3; instr = addi(9, 7); in_valid = 1'b1;
    @(posedge clk); #1;
    instr = addi(10, 8);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'd0);
    chk("async_rst_rd_data", rd_data, 32'd0);
    chk("async_rst_a_data", a_data, 32'd0);
    chk("async_rst_in_ready", 32'(in_ready), 32'd1);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // Randomized traffic against the reference model
    @(posedge clk); #1;
    sb_on = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      in_valid  = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      flush     = $urandom_range(0, 40) == 0;
      instr     = rand_instr();
      pc        = $urandom() & 32'hFFFF_FFFC;
      x         = $urandom();
      rs1       = x;
      rs2       = ($urandom_range(0, 3) == 0) ? x : $urandom();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 10 && q.size() != 0; c++) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'd0);
    sb_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
